// File: rtl/instruction_loader_pkg.sv
// Shared constants for the instruction memory loader: instruction geometry,
// the NOP encoding and the loader FSM state encodings.
package instruction_loader_pkg;

  localparam int unsigned InstLen      = 32;
  localparam int unsigned InstMemSize  = 1024;
  localparam int unsigned ByteW        = 8;
  localparam int unsigned BytesPerInst = InstLen / ByteW;

  localparam logic [InstLen-1:0] NopInst = 32'hE0000000;

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StLoad   = 2'd1,
    StCheck  = 2'd2,
    StFinish = 2'd3
  } loader_state_e;

endpackage

// File: rtl/instruction_loader_byte_packer.sv
// Byte index and big-endian shift register assembling stream bytes into
// instruction words; the first byte lands in the most-significant lane.
module loader_byte_packer
  import instruction_loader_pkg::*;
#(
  parameter int unsigned WORD_W = InstLen
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear,
  input  logic              byte_valid,
  input  logic [ByteW-1:0]  byte_data,
  output logic              last_byte,
  output logic              word_valid,
  output logic [WORD_W-1:0] word
);

  localparam int unsigned NBytes = WORD_W / ByteW;
  localparam int unsigned IdxW   = $clog2(NBytes);

  logic [IdxW-1:0]         idx_q;
  logic [WORD_W-ByteW-1:0] shreg_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_q   <= '0;
      shreg_q <= '0;
    end else if (clear) begin
      idx_q   <= '0;
      shreg_q <= '0;
    end else if (byte_valid) begin
      idx_q   <= idx_q + 1'b1;
      shreg_q <= {shreg_q[WORD_W-2*ByteW-1:0], byte_data};
    end
  end

  assign last_byte  = (idx_q == IdxW'(NBytes - 1));
  assign word_valid = byte_valid && last_byte;
  // Combinational completion so the word is usable on its accepting edge.
  assign word       = {shreg_q, byte_data};

endmodule

// File: rtl/instruction_loader.sv
// Streams a program into the byte-wide instruction memory while stalling the core.
// Optional trailing checksum word: define INSTRUCTION_LOADER_CHECKSUM_EN.
module instruction_loader
  import instruction_loader_pkg::*;
#(
  parameter int unsigned INST_LEN = InstLen,
  parameter int unsigned MEM_SIZE = InstMemSize,
  parameter int unsigned ADDR_W   = 32,
  parameter int unsigned CNT_W    = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [CNT_W-1:0]  word_count,
  input  logic              in_valid,
  input  logic [ByteW-1:0]  in_data,
  output logic              in_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [ByteW-1:0]  mem_wdata,
  output logic              cpu_hold,
  output logic              busy,
  output logic              done,
  output logic              error
);

  localparam logic [ADDR_W-1:0] OffMask = ADDR_W'(MEM_SIZE - 1);

  loader_state_e      state_q;
  logic [ADDR_W-1:0]  addr_q, addr_inc;
  logic [CNT_W-1:0]   remain_q;
  logic               mem_we_q, done_q;
  logic [ADDR_W-1:0]  mem_addr_q;
  logic [ByteW-1:0]   mem_wdata_q;
  logic               accept, start_take, last_byte, last_word, word_valid;
  logic [INST_LEN-1:0] word;

  assign in_ready   = (state_q == StLoad) || (state_q == StCheck);
  assign accept     = in_valid && in_ready;
  assign start_take = (state_q == StIdle) && start;
  assign last_word  = (remain_q == CNT_W'(1));
  // Increment within the memory window, keeping any upper address bits.
  assign addr_inc   = (addr_q & ~OffMask) | ((addr_q + 1'b1) & OffMask);

  loader_byte_packer #(
    .WORD_W(INST_LEN)
  ) u_packer (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear     (start_take),
    .byte_valid(accept),
    .byte_data (in_data),
    .last_byte (last_byte),
    .word_valid(word_valid),
    .word      (word)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      addr_q      <= '0;
      remain_q    <= '0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      done_q      <= 1'b0;
    end else begin
      mem_we_q <= 1'b0;
      done_q   <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (start) begin
            addr_q   <= base_addr & ~ADDR_W'(3);
            remain_q <= word_count;
            state_q  <= (word_count == '0) ? StFinish : StLoad;
          end
        end
        StLoad: begin
          if (accept) begin
            mem_we_q    <= 1'b1;
            mem_addr_q  <= addr_q;
            mem_wdata_q <= in_data;
            addr_q      <= addr_inc;
            if (last_byte) begin
              remain_q <= remain_q - 1'b1;
              if (last_word) begin
`ifdef INSTRUCTION_LOADER_CHECKSUM_EN
                state_q <= StCheck;
`else
                state_q <= StFinish;
`endif
              end
            end
          end
        end
`ifdef INSTRUCTION_LOADER_CHECKSUM_EN
        StCheck: begin
          if (word_valid) state_q <= StFinish;
        end
`endif
        StFinish: begin
          done_q  <= 1'b1;
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

`ifdef INSTRUCTION_LOADER_CHECKSUM_EN
  logic [INST_LEN-1:0] csum_q;
  logic                error_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      csum_q  <= '0;
      error_q <= 1'b0;
    end else if (start_take) begin
      csum_q  <= '0;
      error_q <= 1'b0;
    end else if (word_valid) begin
      if (state_q == StLoad) begin
        csum_q <= csum_q ^ word;
      end else if ((state_q == StCheck) && (word != csum_q)) begin
        error_q <= 1'b1;
      end
    end
  end

  assign error = error_q;
`else
  logic unused_word;
  assign unused_word = ^{word, word_valid};
  assign error       = 1'b0;
`endif

  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign done      = done_q;
  assign busy      = (state_q != StIdle);
  assign cpu_hold  = busy;

endmodule

// File: tb/tb_instruction_loader.sv
// Directed self-checking bench for instruction_loader with a byte memory model.
module tb_instruction_loader;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [31:0] base_addr = '0;
  logic [15:0] word_count = '0;
  logic        in_valid = 1'b0;
  logic [7:0]  in_data = '0;
  logic        in_ready, mem_we, cpu_hold, busy, done, error;
  logic [31:0] mem_addr;
  logic [7:0]  mem_wdata;

  always #5 clk = ~clk;

  instruction_loader dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .base_addr (base_addr),
    .word_count(word_count),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .cpu_hold  (cpu_hold),
    .busy      (busy),
    .done      (done),
    .error     (error)
  );

`ifdef INSTRUCTION_LOADER_CHECKSUM_EN
  localparam int CsCycles = 4;
`else
  localparam int CsCycles = 0;
`endif

  int          checks = 0;
  int          errors = 0;
  int          cyc, wr_cnt, hold_cnt, done_cnt, done_cyc, first_we;
  logic [7:0]  mem [1024];
  logic [7:0]  byte_q [$];
  logic [31:0] exp_xor;

  function automatic logic [31:0] rd_word(input int a);
    return {mem[a % 1024], mem[(a + 1) % 1024], mem[(a + 2) % 1024], mem[(a + 3) % 1024]};
  endfunction

  task automatic push_raw(input logic [31:0] w);
    byte_q.push_back(w[31:24]);
    byte_q.push_back(w[23:16]);
    byte_q.push_back(w[15:8]);
    byte_q.push_back(w[7:0]);
  endtask

  task automatic push_word(input logic [31:0] w);
    push_raw(w);
    exp_xor ^= w;
  endtask

  task automatic push_cs();
`ifdef INSTRUCTION_LOADER_CHECKSUM_EN
    push_raw(exp_xor);
`endif
  endtask

  task automatic clear_stream();
    byte_q.delete();
    exp_xor = '0;
  endtask

  task automatic clear_mem();
    for (int i = 0; i < 1024; i++) mem[i] = 8'h00;
  endtask

  task automatic clear_counters();
    cyc = 0; wr_cnt = 0; hold_cnt = 0; done_cnt = 0; done_cyc = -1; first_we = -1;
  endtask

  // Advance to the next falling edge and sample the write port and status.
  task automatic tick();
    @(negedge clk);
    cyc++;
    if (mem_we) begin
      mem[mem_addr[9:0]] = mem_wdata;
      wr_cnt++;
      if (first_we < 0) first_we = cyc;
    end
    if (cpu_hold) hold_cnt++;
    if (done) begin
      done_cnt++;
      if (done_cyc < 0) done_cyc = cyc;
    end
  endtask

  // Start a load and stream byte_q; restart_at pulses a second start at that byte index.
  task automatic run_load(input logic [31:0] base, input logic [15:0] n, input bit gaps,
                          input int restart_at);
    int  idx, guard;
    bit  acc, restarted;
    clear_counters();
    idx = 0; guard = 0; restarted = 1'b0;
    start = 1'b1; base_addr = base; word_count = n; in_valid = 1'b0;
    tick();
    start = 1'b0;
    while (idx < byte_q.size() && guard < 400) begin
      in_valid = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
      in_data  = byte_q[idx];
      if (idx == restart_at && !restarted) begin
        restarted = 1'b1;
        start = 1'b1; base_addr = 32'h0; word_count = 16'd7;
      end
      acc = in_valid && in_ready;
      tick();
      start = 1'b0;
      if (acc) idx++;
      guard++;
    end
    in_valid = 1'b0;
    while (done_cnt == 0 && guard < 400) begin
      tick();
      guard++;
    end
    repeat (3) tick();
    if (guard >= 400) begin
      errors++;
      $display("FAIL load_timeout: consumed %0d of %0d bytes, done_cnt %0d", idx, byte_q.size(),
               done_cnt);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if ({in_ready, mem_we, cpu_hold, busy, done, error} !== 6'b0) begin
      errors++;
      $display("FAIL reset_flags: got %b expected 000000",
               {in_ready, mem_we, cpu_hold, busy, done, error});
    end
    checks++;
    if (mem_addr !== 32'h0) begin
      errors++; $display("FAIL reset_addr: got %h expected 0", mem_addr);
    end
    checks++;
    if (mem_wdata !== 8'h0) begin
      errors++; $display("FAIL reset_wdata: got %h expected 0", mem_wdata);
    end
    rst_n = 1'b1;
    clear_counters();
    repeat (2) tick();
    checks++;
    if (busy !== 1'b0 || wr_cnt != 0) begin
      errors++; $display("FAIL idle_after_reset: busy %b writes %0d expected 0 0", busy, wr_cnt);
    end
  endtask

  task automatic test_basic();
    clear_mem(); clear_stream();
    push_word(32'hE3A00014); push_cs();
    run_load(32'h0, 16'd1, 1'b0, -1);
    checks++;
    if (done_cyc != 6 + CsCycles) begin
      errors++; $display("FAIL basic_done_cycle: got %0d expected %0d", done_cyc, 6 + CsCycles);
    end
    checks++;
    if (first_we != 2) begin
      errors++; $display("FAIL basic_first_we: got %0d expected 2", first_we);
    end
    checks++;
    if (rd_word(0) !== 32'hE3A00014) begin
      errors++; $display("FAIL basic_image: got %h expected e3a00014", rd_word(0));
    end
    checks++;
    if (wr_cnt != 4) begin
      errors++; $display("FAIL basic_writes: got %0d expected 4", wr_cnt);
    end
    checks++;
    if (done_cnt != 1) begin
      errors++; $display("FAIL basic_done_pulses: got %0d expected 1", done_cnt);
    end
    checks++;
    if (hold_cnt != 5 + CsCycles) begin
      errors++; $display("FAIL basic_hold: got %0d expected %0d", hold_cnt, 5 + CsCycles);
    end
  endtask

  task automatic test_wrap();
    clear_mem(); clear_stream();
    push_word(32'h11223344); push_cs();
    run_load(32'h3FE, 16'd1, 1'b0, -1);
    checks++;
    if (rd_word(32'h3FC) !== 32'h11223344) begin
      errors++; $display("FAIL align_image: got %h expected 11223344", rd_word(32'h3FC));
    end
    checks++;
    if (mem[0] !== 8'h00 || wr_cnt != 4) begin
      errors++; $display("FAIL align_extent: mem0 %h writes %0d expected 00 4", mem[0], wr_cnt);
    end
    clear_mem(); clear_stream();
    push_word(32'hAABBCCDD); push_word(32'h01020304); push_cs();
    run_load(32'h3FC, 16'd2, 1'b0, -1);
    checks++;
    if (rd_word(32'h3FC) !== 32'hAABBCCDD) begin
      errors++; $display("FAIL wrap_word0: got %h expected aabbccdd", rd_word(32'h3FC));
    end
    checks++;
    if (rd_word(0) !== 32'h01020304) begin
      errors++; $display("FAIL wrap_word1: got %h expected 01020304", rd_word(0));
    end
    checks++;
    if (done_cyc != 10 + CsCycles) begin
      errors++; $display("FAIL wrap_done_cycle: got %0d expected %0d", done_cyc, 10 + CsCycles);
    end
    checks++;
    if (wr_cnt != 8) begin
      errors++; $display("FAIL wrap_writes: got %0d expected 8", wr_cnt);
    end
  endtask

  task automatic test_zero();
    clear_stream();
    run_load(32'h40, 16'd0, 1'b0, -1);
    checks++;
    if (wr_cnt != 0) begin
      errors++; $display("FAIL zero_writes: got %0d expected 0", wr_cnt);
    end
    checks++;
    if (done_cyc != 2) begin
      errors++; $display("FAIL zero_done_cycle: got %0d expected 2", done_cyc);
    end
    checks++;
    if (hold_cnt != 1) begin
      errors++; $display("FAIL zero_hold: got %0d expected 1", hold_cnt);
    end
  endtask

  task automatic test_gaps();
    clear_mem(); clear_stream();
    push_word(32'h12345678); push_word(32'h9ABCDEF0); push_word(32'h0F1E2D3C); push_cs();
    run_load(32'h100, 16'd3, 1'b1, 5);
    checks++;
    if (wr_cnt != 12) begin
      errors++; $display("FAIL gaps_writes: got %0d expected 12", wr_cnt);
    end
    checks++;
    if ({rd_word(32'h100), rd_word(32'h104), rd_word(32'h108)} !==
        {32'h12345678, 32'h9ABCDEF0, 32'h0F1E2D3C}) begin
      errors++;
      $display("FAIL gaps_image: got %h %h %h expected 12345678 9abcdef0 0f1e2d3c",
               rd_word(32'h100), rd_word(32'h104), rd_word(32'h108));
    end
    checks++;
    if (rd_word(0) !== 32'h0) begin
      errors++; $display("FAIL gaps_restart_ignored: got %h at 0 expected 0", rd_word(0));
    end
    checks++;
    if (done_cnt != 1 || busy !== 1'b0) begin
      errors++; $display("FAIL gaps_done: pulses %0d busy %b expected 1 0", done_cnt, busy);
    end
  endtask

  task automatic test_reset_mid();
    clear_mem(); clear_stream(); clear_counters();
    push_word(32'h01020304); push_word(32'h05060708);
    start = 1'b1; base_addr = 32'h200; word_count = 16'd2; in_valid = 1'b0;
    tick();
    start = 1'b0; in_valid = 1'b1;
    for (int k = 0; k < 5; k++) begin
      in_data = byte_q[k];
      tick();
    end
    in_data = byte_q[5];
    @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    checks++;
    if ({in_ready, mem_we, cpu_hold, busy, done, error} !== 6'b0) begin
      errors++;
      $display("FAIL midreset_flags: got %b expected 000000",
               {in_ready, mem_we, cpu_hold, busy, done, error});
    end
    checks++;
    if (mem_addr !== 32'h0 || mem_wdata !== 8'h0) begin
      errors++; $display("FAIL midreset_port: addr %h data %h expected 0 0", mem_addr, mem_wdata);
    end
    in_valid = 1'b0;
    tick();
    checks++;
    if (wr_cnt != 5) begin
      errors++; $display("FAIL midreset_writes: got %0d expected 5", wr_cnt);
    end
    checks++;
    if ({rd_word(32'h200), mem[32'h204], mem[32'h205]} !== {32'h01020304, 8'h05, 8'h00}) begin
      errors++;
      $display("FAIL midreset_image: got %h %h %h expected 01020304 05 00", rd_word(32'h200),
               mem[32'h204], mem[32'h205]);
    end
    rst_n = 1'b1;
    tick();
    clear_stream();
    push_word(32'hDEADBEEF); push_cs();
    run_load(32'h200, 16'd1, 1'b0, -1);
    checks++;
    if (rd_word(32'h200) !== 32'hDEADBEEF) begin
      errors++; $display("FAIL reload_image: got %h expected deadbeef", rd_word(32'h200));
    end
    checks++;
    if (done_cyc != 6 + CsCycles) begin
      errors++; $display("FAIL reload_done_cycle: got %0d expected %0d", done_cyc, 6 + CsCycles);
    end
  endtask

`ifdef INSTRUCTION_LOADER_CHECKSUM_EN
  task automatic test_checksum();
    clear_stream();
    push_word(32'h1); push_word(32'h2); push_raw(32'h3);
    run_load(32'h40, 16'd2, 1'b0, -1);
    checks++;
    if (error !== 1'b0) begin
      errors++; $display("FAIL cs_good: error %b expected 0", error);
    end
    clear_stream();
    push_word(32'h1); push_word(32'h2); push_raw(32'h0);
    run_load(32'h40, 16'd2, 1'b0, -1);
    checks++;
    if (error !== 1'b1) begin
      errors++; $display("FAIL cs_bad: error %b expected 1", error);
    end
    repeat (4) tick();
    checks++;
    if (error !== 1'b1) begin
      errors++; $display("FAIL cs_sticky: error %b expected 1", error);
    end
    start = 1'b1; word_count = 16'd0;
    tick();
    start = 1'b0;
    checks++;
    if (error !== 1'b0) begin
      errors++; $display("FAIL cs_clear_on_start: error %b expected 0", error);
    end
    repeat (3) tick();
  endtask
`endif

  initial begin
    clear_mem();
    clear_stream();
    clear_counters();
    test_reset();
    test_basic();
    test_wrap();
    test_zero();
    test_gaps();
    test_reset_mid();
`ifdef INSTRUCTION_LOADER_CHECKSUM_EN
    test_checksum();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/instruction_loader.md
# instruction_loader

Writer-side counterpart of the instruction memory. Accepts a program as a byte stream over a valid/ready handshake and writes it into the byte-wide instruction memory write port, most-significant byte of each instruction at the lowest address. It holds the core in stall (`cpu_hold`) for the whole load. Used at boot and by the test harness to place programs without editing memory initialisation.

## Interface
- `INST_LEN`, 32: instruction width in bits; 4 bytes per instruction.
- `MEM_SIZE`, 1024: instruction memory size in bytes; power of two.
- `ADDR_W`, 32: address width, matching the instruction address bus.
- `CNT_W`, 16: width of `word_count`.

Ports:
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: reset, asynchronous, active-low.
- `start` in 1: one-cycle pulse that begins a load.
- `base_addr` in ADDR_W: first byte address; bits [1:0] forced to 0.
- `word_count` in CNT_W: number of instructions to load.
- `in_valid` in 1: stream byte valid.
- `in_data` in 8: stream byte.
- `in_ready` out 1: loader accepts a byte this cycle.
- `mem_we` out 1: byte write strobe to instruction memory.
- `mem_addr` out ADDR_W: byte write address.
- `mem_wdata` out 8: byte write data.
- `cpu_hold` out 1: stall request to the fetch stage.
- `busy` out 1: load in progress.
- `done` out 1: one-cycle completion pulse.
- `error` out 1: sticky checksum mismatch; CHECKSUM_EN only, otherwise tied 0.

## Operation
- FSM states: IDLE, LOAD, CHECK (CHECKSUM_EN only), FINISH.
- IDLE + `start`:
  - Latch `base_addr & ~3` into the address counter.
  - Latch `word_count` and clear the byte index (0..3).
  - If `word_count` == 0, go to FINISH; otherwise go to LOAD.
  - Clear `error` only when `start` is taken.
- LOAD:
  - `in_ready` = 1.
  - Each accepted byte (`in_valid && in_ready`) is written to the current address.
  - The address increments by 1 modulo MEM_SIZE; it wraps from MEM_SIZE-1 to 0.
  - The byte index increments; the 4th byte completes a word and decrements the remaining count.
  - After the last byte of the last word, go to CHECK if enabled, else FINISH.
- CHECK: accept 4 more bytes, big-endian, forming the checksum word. These bytes are not written to memory. Then go to FINISH; set `error` if the checksum word differs from the running XOR.
- FINISH: pulse `done`, return to IDLE.
- `start` while not in IDLE is ignored.
- `in_valid` outside LOAD/CHECK is ignored; no byte is consumed.
- `cpu_hold` = `busy` = (state != IDLE).

## Timing
- Reset values: state IDLE; `in_ready`, `mem_we`, `cpu_hold`, `busy`, `done`, `error` = 0; `mem_addr`, `mem_wdata` = 0.
- `mem_we`, `mem_addr` and `mem_wdata` are registered: they are asserted the cycle after the accepting edge and last one cycle.
- Throughput is 1 byte/cycle.
- Minimum load time is 4·N + 2 cycles from `start` to `done` with `in_valid` held high; add 4 cycles with CHECKSUM_EN.
- `in_ready` goes high the cycle after `start` is sampled.
- `in_ready` drops combinationally with the state, so no byte beyond the last is accepted.
- `done` is high exactly one cycle, the cycle after the last accepted byte plus one FINISH cycle. `busy` falls in the same cycle `done` rises.
- `in_valid` gaps stall the counters with no side effects.
- Reset mid-load: return to IDLE immediately. Bytes already written stay in memory; a pending `mem_we` is cancelled.

## Configuration
- `INSTRUCTION_LOADER_CHECKSUM_EN` defined:
  - Running 32-bit XOR over all loaded words.
  - CHECK state and trailing checksum word.
  - `error` is live.
- Not defined: no CHECK state, `error` tied 0, stream length is exactly 4·`word_count` bytes.

## Structure
- Shared constants file holds:
  - Instruction length, instruction memory size, byte width.
  - The NOP encoding `32'hE0000000`.
  - The loader state encodings.
- One sub-module, `loader_byte_packer`:
  - Contains the byte index and the big-endian 4-byte shift register.
  - Produces `word_valid` and `word` for the checksum XOR and CHECK compare.
- The FSM, counters and write-port registers live in the top.

## Test plan
- Reset, then load 1 word `E3A00014` at base 0 with continuous `in_valid` → bytes E3, A0, 00, 14 written to 0..3; `done` pulses at cycle 6 after `start`; memory reads back `E3A00014`.
- Base `0x3FE`, 1 word → address forced to `0x3FC`; 2 words from `0x3FC` → second word at 0x000..0x003 (wrap).
- `word_count` = 0 → no `mem_we`; `done` 2 cycles after `start`; `cpu_hold` high for exactly 1 cycle.
- Random `in_valid` gaps over 3 words; `start` pulsed mid-load → identical memory image; second `start` ignored; exactly 12 writes.
- `rst_n` asserted after 5 bytes → all outputs 0 at once; bytes 0..4 remain; the next `start` loads normally.
- CHECKSUM_EN, words 1 and 2 with checksum 3 → `error` 0; with checksum 0 → `error` 1 and stays 1 until the next `start`.
